// File: rtl/sma_rr_sched.sv
// Round-robin scheduler sharing one 4-tap moving-average datapath among four
// requester channels, with per-channel history and running-sum accumulators.
module sma_rr_sched #(
  parameter int NCH = 4,
  parameter int DW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [1:0]        out_ch,
  input  logic              out_ready
);

  localparam int AW = DW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           rr_q, rr_d;
  logic [1:0]           ch_q, ch_d;
  logic signed [DW-1:0] x_q, x_d;
  logic [DW-1:0]        out_data_q, out_data_d;

  logic signed [DW-1:0] hist_q [NCH][4];
  logic signed [AW-1:0] acc_q  [NCH];

  logic [NCH-1:0]       grant_s;
  logic [1:0]           gnt_idx_s;
  logic [1:0]           scan_idx_s;
  logic                 found_s;
  logic signed [DW-1:0] x_sel_s;
  logic signed [AW-1:0] acc_new_s;

  // Round-robin search for the first valid channel starting at rr_q.
  always_comb begin
    grant_s    = '0;
    gnt_idx_s  = rr_q;
    scan_idx_s = rr_q;
    found_s    = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx_s = rr_q + k[1:0];
      if (!found_s && in_valid[scan_idx_s]) begin
        found_s             = 1'b1;
        grant_s[scan_idx_s] = 1'b1;
        gnt_idx_s           = scan_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Sample lane of the granted channel.
  always_comb begin
    x_sel_s = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_idx_s == k[1:0]) begin
        x_sel_s = in_data[k*DW +: DW];
      end else begin
        x_sel_s = x_sel_s;
      end
    end
  end

  // Running sum: drop the oldest tap, add the new sample (18-bit wrap).
  always_comb begin
    acc_new_s = acc_q[ch_q]
              - {{2{hist_q[ch_q][3][DW-1]}}, hist_q[ch_q][3]}
              + {{2{x_q[DW-1]}}, x_q};
  end

  // Grants are withheld during reset so the interface is quiet asynchronously.
  assign in_ready  = (rst && (state_q == IDLE) && !flush) ? grant_s : '0;
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_ch    = ch_q;

  // Next-state and transaction-capture logic.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    ch_d       = ch_q;
    x_d        = x_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (|in_ready) begin
          ch_d    = gnt_idx_s;
          x_d     = x_sel_s;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        out_data_d = acc_new_s[DW+1:2];
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          rr_d    = ch_q + 2'd1;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; untouched by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_q       <= 2'd0;
      ch_q       <= 2'd0;
      x_q        <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      ch_q       <= ch_d;
      x_q        <= x_d;
      out_data_q <= out_data_d;
    end
  end

  // Per-channel history and accumulators; flush beats a same-edge update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        acc_q[c] <= '0;
        for (int t = 0; t < 4; t++) hist_q[c][t] <= '0;
      end
    end else if (flush) begin
      for (int c = 0; c < NCH; c++) begin
        acc_q[c] <= '0;
        for (int t = 0; t < 4; t++) hist_q[c][t] <= '0;
      end
    end else if (state_q == CALC) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_q == c[1:0]) begin
          acc_q[c]     <= acc_new_s;
          hist_q[c][3] <= hist_q[c][2];
          hist_q[c][2] <= hist_q[c][1];
          hist_q[c][1] <= hist_q[c][0];
          hist_q[c][0] <= x_q;
        end else begin
          acc_q[c] <= acc_q[c];
        end
      end
    end else begin
      acc_q <= acc_q;
    end
  end

endmodule

// File: tb/tb_sma_rr_sched.sv
// Scoreboard bench for sma_rr_sched: a reference model predicts each result at
// its input handshake; the monitor pops and compares when the output handshakes.
module tb_sma_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        flush;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  always #5 clk = ~clk;

  sma_rr_sched #(.NCH(4), .DW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
    int          hs;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          grant_cyc[$];
  logic [15:0] out_log[$];
  logic [1:0]  och_log[$];
  logic [15:0] ed[$];
  logic [1:0]  ec[$];

  logic signed [15:0] m_h[4][4];
  logic signed [17:0] m_acc[4];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit ov_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step(input int ch, input logic signed [15:0] x, output logic [15:0] r);
    logic signed [17:0] h3e;
    logic signed [17:0] xe;
    logic signed [17:0] a;
    h3e = m_h[ch][3];
    xe  = x;
    a   = m_acc[ch] - h3e + xe;
    r   = a[17:2];
    m_h[ch][3] = m_h[ch][2];
    m_h[ch][2] = m_h[ch][1];
    m_h[ch][1] = m_h[ch][0];
    m_h[ch][0] = x;
    m_acc[ch]  = a;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: predicts at input handshakes, compares at output handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      ov_prev = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_acc[c] = '0;
        for (int t = 0; t < 4; t++) m_h[c][t] = '0;
      end
    end else begin
      if (|(in_valid & in_ready)) begin
        exp_t e;
        int   g;
        g = 0;
        for (int c = 0; c < 4; c++) if (in_ready[c]) g = c;
        check_val("onehot", $countones(in_ready), 1);
        model_step(g, in_data[16*g +: 16], e.data);
        e.ch = g[1:0];
        e.hs = cyc;
        sb.push_back(e);
        grant_log.push_back(g);
        grant_cyc.push_back(cyc);
      end
      if (flush) begin
        for (int c = 0; c < 4; c++) begin
          m_acc[c] = '0;
          for (int t = 0; t < 4; t++) m_h[c][t] = '0;
        end
      end
      if (out_valid && !ov_prev) begin
        if (sb.size() > 0) check_val("latency", cyc - sb[0].hs, 2);
        else check_val("spurious_out", 1, 0);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_val("sb_ch", out_ch, e.ch);
        check_val("sb_data", out_data, e.data);
        out_log.push_back(out_data);
        och_log.push_back(out_ch);
      end
      ov_prev = out_valid;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b0; in_valid = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic send(input int ch, input logic [15:0] v, input bit flush_calc);
    bit got;
    got = 1'b0;
    @(posedge clk); #2;
    in_valid[ch] = 1'b1;
    in_data[16*ch +: 16] = v;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready[ch]) begin
        got = 1'b1;
        break;
      end
    end
    check_val("handshake", got, 1);
    @(posedge clk); #2;
    in_valid[ch] = 1'b0;
    if (flush_calc) begin
      flush = 1'b1;
      @(posedge clk); #2;
      flush = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    check_val("drain", done, 1);
  endtask

  task automatic check_log(input string tag);
    check_val({tag, "_count"}, out_log.size(), ed.size());
    for (int i = 0; i < ed.size() && i < out_log.size(); i++) begin
      check_val($sformatf("%s_data%0d", tag, i), out_log[i], ed[i]);
      check_val($sformatf("%s_ch%0d", tag, i), och_log[i], ec[i]);
    end
    out_log.delete();
    och_log.delete();
  endtask

  initial begin
    bit seen;
    rst = 1'b0; in_valid = 4'hF; flush = 1'b0; out_ready = 1'b1;
    in_data = {16'd16, 16'd12, 16'd8, 16'd4};
    #12;
    check_val("rst_in_ready", in_ready, 4'h0);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, 16'h0000);
    check_val("rst_out_ch", out_ch, 2'd0);

    // Four requesters held valid from reset.
    @(posedge clk); #2 rst = 1'b1;
    for (int k = 0; k < 100 && grant_log.size() < 6; k++) @(posedge clk);
    #2 in_valid = 4'h0;
    check_val("rr_grants", grant_log.size() >= 6, 1);
    if (grant_log.size() >= 6) begin
      ed = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
      for (int i = 0; i < 6; i++) check_val($sformatf("rr_order%0d", i), grant_log[i], ed[i]);
      for (int i = 1; i < 6; i++) check_val($sformatf("rr_gap%0d", i), grant_cyc[i] - grant_cyc[i-1], 3);
    end
    drain();

    // Channel 0 ramp.
    apply_reset();
    out_log.delete(); och_log.delete();
    for (int i = 1; i <= 5; i++) begin
      send(0, 16'(4 * i), 1'b0);
      drain();
    end
    ed = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd14};
    ec = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    check_log("ramp");

    // Most-negative samples interleaved with another channel.
    apply_reset();
    send(1, 16'h8000, 1'b0); drain();
    send(2, 16'd100, 1'b0);  drain();
    send(1, 16'h8000, 1'b0); drain();
    send(2, 16'd100, 1'b0);  drain();
    send(1, 16'h8000, 1'b0); drain();
    send(1, 16'h8000, 1'b0); drain();
    ed = '{-16'sd8192, 16'd25, -16'sd16384, 16'd50, -16'sd24576, -16'sd32768};
    ec = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1};
    check_log("neg");

    // Floor of -1/4 and a stalled consumer.
    out_ready = 1'b0;
    send(3, 16'hFFFF, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("stall_seen", seen, 1);
    in_valid = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("stall_valid", out_valid, 1'b1);
      check_val("stall_data", out_data, 16'hFFFF);
      check_val("stall_ch", out_ch, 2'd3);
      check_val("stall_in_ready", in_ready, 4'h0);
    end
    @(posedge clk); #2;
    in_valid = 4'h0; out_ready = 1'b1;
    drain();
    ed = '{16'hFFFF};
    ec = '{2'd3};
    check_log("floor");

    // Flush while idle, then flush coinciding with the update edge.
    apply_reset();
    for (int i = 0; i < 4; i++) begin send(0, 16'd400, 1'b0); drain(); end
    @(posedge clk); #2 flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
    send(0, 16'd400, 1'b0); drain();
    for (int i = 0; i < 3; i++) begin send(0, 16'd400, 1'b0); drain(); end
    send(0, 16'd400, 1'b1); drain();
    send(0, 16'd400, 1'b0); drain();
    ed = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd100, 16'd200, 16'd300, 16'd400, 16'd400, 16'd100};
    ec = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    check_log("flush");

    // Reset while a result is waiting.
    out_ready = 1'b0;
    send(2, 16'd1000, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("midrst_seen", seen, 1);
    #3 rst = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 1'b0);
    check_val("midrst_out_data", out_data, 16'h0000);
    check_val("midrst_out_ch", out_ch, 2'd0);
    check_val("midrst_in_ready", in_ready, 4'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1; out_ready = 1'b1;
    out_log.delete(); och_log.delete();
    send(2, 16'd8, 1'b0); drain();
    ed = '{16'd2};
    ec = '{2'd2};
    check_log("postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
